// File: rtl/spi_regfile_periph.sv
// rtl/spi_regfile_periph.sv - SPI mode-0 register file peripheral with read-back and frame-length checking
//
// Frame is 1 + ADDR_W + DATA_W bits, MSB first: R/W (1 = write), address, data.
// Ports:
//   clk        system clock, at least 8x sclk
//   rst        synchronous active-high reset
//   sclk       SPI clock (async, idle low)
//   ncs        chip select, active low (async)
//   sdi        serial data from controller
//   sdo        serial data to controller
//   sdo_oe     pad output enable for sdo
//   regs_out   register image, register i at [i*DATA_W +: DATA_W]
//   wr_pulse   one-clk pulse on a committed write
//   wr_addr    address of the last committed write
//   frame_err  one-clk pulse when a frame ends with the wrong bit count

module spi_regfile_periph #(
    parameter int                            ADDR_W     = 7,
    parameter int                            DATA_W     = 8,
    parameter int                            NUM_REGS   = 5,
    parameter logic [NUM_REGS*DATA_W-1:0]    RESET_VALS = '0,
    parameter bit                            READ_EN    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         sdi,
    output logic                         sdo,
    output logic                         sdo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CMD_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1) + 1;
    // Shift register only needs to hold the larger of the command or data field;
    // the incoming bit is appended combinationally, so the stored part is one bit shorter.
    localparam int SH_W    = (CMD_W > DATA_W) ? CMD_W : DATA_W;

    localparam logic [CNT_W-1:0]  CNT_CMD    = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    logic ncs_s1, ncs_s2, ncs_d;
    logic sclk_s1, sclk_s2, sclk_d;
    logic sdi_s1, sdi_s2;
    logic sclk_rise, sclk_fall, ncs_fall, ncs_rise;

    logic [2:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [SH_W-2:0]   rx_shift;
    logic [SH_W-1:0]   rx_next;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] data_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_in_range;
    logic              addr_in_range;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] regs [NUM_REGS];

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ncs_fall  = ~ncs_s2 & ncs_d;
    assign ncs_rise  = ncs_s2 & ~ncs_d;

    assign rx_next       = {rx_shift, sdi_s2};
    assign cnt_inc       = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
    assign cmd_rw        = rx_next[CMD_W-1];
    assign cmd_addr      = rx_next[ADDR_W-1:0];
    assign cmd_in_range  = ({1'b0, cmd_addr} < NUM_REGS_L);
    assign addr_in_range = ({1'b0, addr_q} < NUM_REGS_L);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == ADDR_W'(i)) rd_data = regs[i];
        end
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_s1    <= 1'b1;
            ncs_s2    <= 1'b1;
            ncs_d     <= 1'b1;
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_d    <= 1'b0;
            sdi_s1    <= 1'b0;
            sdi_s2    <= 1'b0;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            data_q    <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALS[i*DATA_W +: DATA_W];
            end
        end else begin
            ncs_s1    <= ncs;
            ncs_s2    <= ncs_s1;
            ncs_d     <= ncs_s2;
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_d    <= sclk_s2;
            sdi_s1    <= sdi;
            sdi_s2    <= sdi_s1;
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;

            // End of frame takes priority over any sclk edge seen in the same cycle.
            if (ncs_rise) begin
                sdo_oe <= 1'b0;
                sdo    <= 1'b0;
                state  <= ST_IDLE;
                case (state)
                    ST_DONE: begin
                        if (rw_q && addr_in_range) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_q == ADDR_W'(i)) regs[i] <= data_q;
                            end
                            wr_pulse <= 1'b1;
                            wr_addr  <= addr_q;
                        end
                    end
                    ST_CMD, ST_DATA, ST_ABORT: frame_err <= 1'b1;
                    default: ;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ncs_fall) begin
                            state    <= ST_CMD;
                            bit_cnt  <= '0;
                            rx_shift <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next[SH_W-2:0];
                            bit_cnt  <= cnt_inc;
                            if (cnt_inc == CNT_CMD) begin
                                rw_q   <= cmd_rw;
                                addr_q <= cmd_addr;
                                state  <= ST_DATA;
                                // Out-of-range reads still drive the pad, with zeros.
                                if (READ_EN && !cmd_rw) begin
                                    sdo_oe   <= 1'b1;
                                    tx_shift <= cmd_in_range ? rd_data : '0;
                                end else begin
                                    tx_shift <= '0;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_fall) begin
                            sdo      <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_shift <= rx_next[SH_W-2:0];
                            bit_cnt  <= cnt_inc;
                            if (cnt_inc == CNT_FRAME) begin
                                data_q <= rx_next[DATA_W-1:0];
                                state  <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (sclk_rise) begin
                            bit_cnt <= cnt_inc;
                            state   <= ST_ABORT;
                        end
                    end
                    ST_ABORT: begin
                        if (sclk_rise) bit_cnt <= cnt_inc;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
Parametrised SPI (mode 0) peripheral that sits between the chip pins and the register-controlled logic (output enables, PWM enables, PWM duty). It generalises the current write-only 5x8-bit SPI register block with configurable address/data width, register count and per-register reset values. It adds read-back over SDO and strict frame-length checking.

Parameters:
ADDR_W, 7, address field width in bits
DATA_W, 8, data field width in bits
NUM_REGS, 5, number of implemented registers, addresses 0..NUM_REGS-1; must satisfy NUM_REGS <= 2**ADDR_W
RESET_VALS, {NUM_REGS*DATA_W{1'b0}}, flat reset image; register i occupies bits [i*DATA_W +: DATA_W]
READ_EN, 1, 1 = read transactions drive SDO; 0 = reads ignored, sdo_oe held 0

Ports:
clk  input  1  system clock; must be >= 8x sclk frequency
rst  input  1  synchronous active-high reset
sclk  input  1  SPI clock, asynchronous to clk, idle low
ncs  input  1  chip select, active low, asynchronous
sdi  input  1  serial data in (controller to peripheral)
sdo  output  1  serial data out (peripheral to controller)
sdo_oe  output  1  SDO output enable, for the pad tristate
regs_out  output  NUM_REGS*DATA_W  register image; register i at bits [i*DATA_W +: DATA_W]
wr_pulse  output  1  one-clk pulse when a register is written
wr_addr  output  ADDR_W  address of the last committed write
frame_err  output  1  one-clk pulse when a frame ends with the wrong bit count

Behaviour:
- Reset is synchronous, active-high, and has priority over everything. On reset: regs_out=RESET_VALS, sdo=0, sdo_oe=0, wr_pulse=0, wr_addr=0, frame_err=0, FSM=IDLE, counters and shift register cleared, synchronisers loaded ncs=1, sclk=0, sdi=0. Reset mid-frame discards the frame; no commit.
- Synchronisation: ncs, sclk and sdi each pass through a 2-FF synchroniser. Edges are detected on the synchronised copies only (sclk_rise, sclk_fall, ncs_fall, ncs_rise).
- Frame format: FRAME_W = 1+ADDR_W+DATA_W bits, sent MSB first.
  - Bit 0: R/W (1 = write, 0 = read).
  - Next: address, then data.
  - sdi is sampled on sclk_rise.
- FSM states: IDLE, CMD, DATA, DONE, ABORT.
- IDLE -> CMD on ncs_fall. Clears bit_cnt and the shift register.
- CMD: shifts in 1+ADDR_W bits. After the last address bit: if read, READ_EN=1 and address < NUM_REGS, load tx_shift with that register; otherwise load zero. Go to DATA.
- Read output during DATA:
  - sdo_oe=1 only for valid reads (READ_EN=1 and R/W=0); otherwise 0.
  - The tx MSB is driven on the first sclk_fall after the last address bit. Each subsequent sclk_fall shifts the next bit.
  - sdo holds its value between falls.
  - Out-of-range reads drive 0x00 with sdo_oe=1.
- DATA: shifts in DATA_W bits. After that count reaches FRAME_W, go to DONE.
- DONE: any further sclk_rise goes to ABORT (overlong frame).
- Any state: ncs_rise ends the frame. sdo_oe drops to 0 in the same cycle as ncs_rise is detected.
  - From DONE with R/W=1 and address < NUM_REGS: in the next clk, the target register = data field, wr_pulse=1 for exactly one clk, and wr_addr = address.
  - From DONE with an out-of-range address: no register change, no wr_pulse, no error.
  - From CMD, DATA, or ABORT, and when a frame ends from DONE as a read: no commit. frame_err=1 for one clk in CMD/DATA/ABORT cases only; a read ending in DONE is not an error.
  - After handling, go to IDLE.
- ncs_fall while not in IDLE is impossible after ncs_rise handling. Simultaneous ncs_rise and sclk_rise in one clk: ncs_rise wins and the bit is ignored.
- bit_cnt width is clog2(FRAME_W+1)+1. It saturates and never wraps.
- Only the addressed register changes. Registers are never modified by reads.

Test Plan:
- Write, defaults: frame 0x84A5 (write, addr 4, data 0xA5) -> regs_out[39:32]=0xA5, other registers 0x00, wr_pulse one clk, wr_addr=4, frame_err=0.
- Read-back: after the write above, frame 0x0400 -> sdo_oe=1 during data bits, sdo returns 1010_0101 on the controller's rising edges, regs unchanged, no wr_pulse.
- Short/long frames: 15 bits of 0x8133, then ncs high -> no update, frame_err pulse. Same with 17 bits -> no update, frame_err pulse.
- Out-of-range: write frame 0x9055 (addr 0x10) -> no register change, no wr_pulse. Read of addr 0x10 -> sdo all 0, sdo_oe=1.
- Reset mid-frame: assert rst after 10 bits of 0x81FF -> all outputs at reset values. Next complete frame 0x81FF -> regs_out[15:8]=0xFF.
- Parameter sweep: DATA_W=16, NUM_REGS=3, RESET_VALS nonzero -> reset image correct. 24-bit write/read to addr 2 round-trips 0xBEEF.
